// File: rtl/hand_scorer.sv
// Blackjack round sequencer: keeps the player and dealer hard sums and ace flags,
// walks PLAYER -> DEALER -> DONE, and resolves soft aces and dealer stand-on-17.
module hand_scorer (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       card_valid,
  input  logic [3:0] card,
  input  logic       stand,
  output logic       turn,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic       player_bust,
  output logic       dealer_bust,
  output logic       done,
  output logic [1:0] result
);

  typedef enum logic [1:0] {IDLE, PLAYER, DEALER, DONE} state_t;

  state_t     state;
  logic [4:0] p_hard, d_hard;
  logic       p_ace, d_ace;

  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    best_total = (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  logic       accept, p_take, d_take;
  logic [4:0] p_hard_n, d_hard_n, p_best_n, d_best_n, p_best;
  logic       p_ace_n, d_ace_n;

  always_comb begin
    accept   = card_valid && (card != 4'd0) && (card <= 4'd10) &&
               (state == PLAYER || state == DEALER);
    p_take   = accept && (state == PLAYER);
    d_take   = accept && (state == DEALER);
    p_hard_n = p_hard + (p_take ? {1'b0, card} : 5'd0);
    d_hard_n = d_hard + (d_take ? {1'b0, card} : 5'd0);
    p_ace_n  = p_ace | (p_take && card == 4'd1);
    d_ace_n  = d_ace | (d_take && card == 4'd1);
    p_best_n = best_total(p_hard_n, p_ace_n);
    d_best_n = best_total(d_hard_n, d_ace_n);
    p_best   = best_total(p_hard, p_ace);
  end

  // Totals and bust flags are pure functions of the registered hands.
  assign player_total = best_total(p_hard, p_ace);
  assign dealer_total = best_total(d_hard, d_ace);
  assign player_bust  = player_total > 5'd21;
  assign dealer_bust  = dealer_total > 5'd21;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      p_hard <= '0;
      d_hard <= '0;
      p_ace  <= 1'b0;
      d_ace  <= 1'b0;
      turn   <= 1'b0;
      done   <= 1'b0;
      result <= 2'b00;
    end else if (start) begin
      state  <= PLAYER;
      p_hard <= '0;
      d_hard <= '0;
      p_ace  <= 1'b0;
      d_ace  <= 1'b0;
      turn   <= 1'b0;
      done   <= 1'b0;
      result <= 2'b00;
    end else begin
      case (state)
        PLAYER: begin
          p_hard <= p_hard_n;
          p_ace  <= p_ace_n;
          if (p_best_n > 5'd21) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= 2'b10;
          end else if (p_best_n == 5'd21 || stand) begin
            state <= DEALER;
            turn  <= 1'b1;
          end
        end
        DEALER: begin
          d_hard <= d_hard_n;
          d_ace  <= d_ace_n;
          if (d_best_n >= 5'd17) begin
            state <= DONE;
            turn  <= 1'b0;
            done  <= 1'b1;
            // Player total is already final; only the dealer hand moves here.
            if (d_best_n > 5'd21 || p_best > d_best_n) result <= 2'b01;
            else if (p_best < d_best_n)                result <= 2'b10;
            else                                       result <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hand_scorer.sv
// Scoreboard bench for hand_scorer: a card-list reference model predicts outputs
// after each edge; a negedge monitor pops and compares.
module tb_hand_scorer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, card_valid = 1'b0, stand = 1'b0;
  logic [3:0] card = 4'd0;
  logic       turn, player_bust, dealer_bust, done;
  logic [4:0] player_total, dealer_total;
  logic [1:0] result;

  hand_scorer dut (
    .clock(clock), .reset(reset), .start(start), .card_valid(card_valid),
    .card(card), .stand(stand), .turn(turn), .player_total(player_total),
    .dealer_total(dealer_total), .player_bust(player_bust),
    .dealer_bust(dealer_bust), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the hands are plain lists of card values.
  int pq[$];
  int dq[$];
  int phase = 0;  // 0 idle, 1 player, 2 dealer, 3 done
  int res   = 0;

  logic [15:0] exp_q[$];

  function automatic int best(input int q[$]);
    int s = 0;
    bit a = 0;
    foreach (q[i]) begin
      s += q[i];
      if (q[i] == 1) a = 1;
    end
    return (a && s + 10 <= 21) ? s + 10 : s;
  endfunction

  function automatic logic [15:0] expected();
    int pb = best(pq);
    int db = best(dq);
    logic [4:0] p5 = pb[4:0];
    logic [4:0] d5 = db[4:0];
    logic [1:0] r2 = res[1:0];
    return {phase == 2, p5, d5, pb > 21, db > 21, phase == 3, r2};
  endfunction

  function automatic logic [15:0] actual();
    return {turn, player_total, dealer_total, player_bust, dealer_bust, done, result};
  endfunction

  task automatic model_step(input bit s, input bit cv, input int c, input bit st);
    int pb, db;
    if (s) begin
      pq.delete();
      dq.delete();
      phase = 1;
      res   = 0;
      return;
    end
    if (cv && c >= 1 && c <= 10) begin
      if (phase == 1) pq.push_back(c);
      else if (phase == 2) dq.push_back(c);
    end
    pb = best(pq);
    db = best(dq);
    if (phase == 1) begin
      if (pb > 21) begin phase = 3; res = 2; end
      else if (pb == 21 || st) phase = 2;
    end else if (phase == 2) begin
      if (db > 21) begin phase = 3; res = 1; end
      else if (db >= 17) begin
        phase = 3;
        res = (pb > db) ? 1 : (pb < db) ? 2 : 3;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got turn=%0d pt=%0d dt=%0d pb=%0d db=%0d done=%0d res=%0d, want turn=%0d pt=%0d dt=%0d pb=%0d db=%0d done=%0d res=%0d",
               name, act[15], act[14:10], act[9:5], act[4], act[3], act[2], act[1:0],
               exp[15], exp[14:10], exp[9:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Drive one cycle of inputs; the expectation is queued once the edge has happened.
  task automatic step(input bit s, input bit cv, input int c, input bit st);
    logic [15:0] e;
    start = s; card_valid = cv; card = c[3:0]; stand = st;
    model_step(s, cv, c, st);
    e = expected();
    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cards(input int a, input int b, input int c3);
    if (a >= 0) step(0, 1, a, 0);
    if (b >= 0) step(0, 1, b, 0);
    if (c3 >= 0) step(0, 1, c3, 0);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) check("outputs", actual(), exp_q.pop_front());
  end

  initial begin
    #1 check("reset_state", actual(), 16'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    step(0, 1, 5, 0);                                  // idle ignores cards
    // blackjack auto-stand
    step(1, 0, 0, 0); cards(1, 10, -1); step(0, 0, 0, 0);
    // player bust, then a card in DONE
    step(1, 0, 0, 0); cards(10, 9, 5); step(0, 1, 3, 0);
    // soft to hard ace
    step(1, 0, 0, 0); cards(1, 6, 9); step(0, 0, 0, 1); step(0, 0, 0, 0);
    // dealer stop / push / bust
    step(1, 0, 0, 0); cards(10, 9, -1); step(0, 0, 0, 1); cards(9, 8, -1);
    step(1, 0, 0, 0); cards(10, 9, -1); step(0, 0, 0, 1); cards(9, 5, 5);
    step(1, 0, 0, 0); cards(10, 9, -1); step(0, 0, 0, 1); cards(9, 5, 9);
    // invalid values, card with stand, start with card
    step(1, 0, 0, 0); cards(0, 12, 10); step(0, 1, 5, 0); step(0, 1, 4, 1);
    step(1, 1, 7, 0); step(1, 1, 3, 0); step(0, 0, 0, 0);

    // asynchronous reset mid-DEALER at dealer total 12
    step(1, 0, 0, 0); cards(10, 9, -1); step(0, 0, 0, 1); cards(10, 2, -1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 check("async_reset", actual(), 16'h0);
    pq.delete(); dq.delete(); phase = 0; res = 0;
    @(posedge clock);
    #1 reset = 1'b1;
    step(0, 1, 7, 0); step(0, 0, 0, 1);

    // randomized rounds
    for (int i = 0; i < 3000; i++) begin
      bit s  = ($urandom_range(0, 39) == 0) || ((phase == 3 || phase == 0) && $urandom_range(0, 3) == 0);
      bit cv = $urandom_range(0, 9) < 6;
      int c  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 10);
      bit st = $urandom_range(0, 6) == 0;
      step(s, cv, c, st);
    end

    start = 0; card_valid = 0; stand = 0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
